// File: rtl/stopwatch_control.sv
// Stopwatch run/stop controller: debounced-edge buttons drive a run/stop FSM and a
// prescaler that emits one-cycle count pulses and clear pulses for a 60-count display.
module stopwatch_control #(
    parameter int TICK_DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic start_stop,
    input  logic clear_req,
    output logic count,
    output logic clear,
    output logic running
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(TICK_DIV - 1);
    localparam logic [W-1:0] DIV_ONE  = W'(1);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t         state_q;
    logic [W-1:0]   div_cnt_q;
    logic [W-1:0]   div_cnt_d;
    logic           ss_prev_q;
    logic           cr_prev_q;
    logic           count_q;
    logic           count_d;
    logic           clear_q;
    logic           clear_d;
    logic           ss_edge_s;
    logic           cr_edge_s;
    logic           is_run_s;
    logic           at_last_s;

    // Edge detection and next values for the prescaler and output pulses.
    always_comb begin
        ss_edge_s = start_stop & ~ss_prev_q;
        cr_edge_s = clear_req & ~cr_prev_q;
        is_run_s  = (state_q == RUNNING);
        at_last_s = (div_cnt_q == DIV_LAST);
        // A stop or clear in the terminal cycle swallows the pending pulse.
        count_d   = is_run_s & at_last_s & ~ss_edge_s & ~cr_edge_s;
        clear_d   = cr_edge_s;
        div_cnt_d = div_cnt_q;
        if (cr_edge_s) begin
            div_cnt_d = {W{1'b0}};
        end else if (is_run_s && !ss_edge_s) begin
            if (at_last_s) begin
                div_cnt_d = {W{1'b0}};
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // FSM, prescaler, button history and registered output pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= STOPPED;
            div_cnt_q <= {W{1'b0}};
            ss_prev_q <= 1'b1;
            cr_prev_q <= 1'b1;
            count_q   <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            case (state_q)
                STOPPED: state_q <= ss_edge_s ? RUNNING : STOPPED;
                RUNNING: state_q <= ss_edge_s ? STOPPED : RUNNING;
                default: state_q <= STOPPED;
            endcase
            div_cnt_q <= div_cnt_d;
            ss_prev_q <= start_stop;
            cr_prev_q <= clear_req;
            count_q   <= count_d;
            clear_q   <= clear_d;
        end
    end

    assign count   = count_q;
    assign clear   = clear_q;
    assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control (TICK_DIV=4): directed scenarios plus random button
// traffic, all checked against a cycle-level behavioural model of the control rules.
module tb_stopwatch_control;

    localparam int TD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_stop = 1'b0;
    logic clear_req = 1'b0;
    logic count;
    logic clear;
    logic running;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int pulses = 0;
    bit last_count = 1'b0;

    // Behavioural model: run flag, cycles elapsed in the current count period.
    bit m_pss = 1'b1;
    bit m_pcr = 1'b1;
    bit m_run = 1'b0;
    int m_el = 0;
    bit m_cnt = 1'b0;
    bit m_clr = 1'b0;

    stopwatch_control #(.TICK_DIV(TD)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_stop (start_stop),
        .clear_req  (clear_req),
        .count      (count),
        .clear      (clear),
        .running    (running)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the present inputs, then compare.
    task automatic tick();
        bit se;
        bit ce;
        if (reset) begin
            m_pss = 1'b1; m_pcr = 1'b1; m_run = 1'b0;
            m_el = 0; m_cnt = 1'b0; m_clr = 1'b0;
        end else begin
            se = start_stop && !m_pss;
            ce = clear_req && !m_pcr;
            m_cnt = m_run && (m_el == TD - 1) && !se && !ce;
            m_clr = ce;
            if (ce) m_el = 0;
            else if (m_run && !se) m_el = (m_el + 1) % TD;
            if (se) m_run = !m_run;
            m_pss = start_stop;
            m_pcr = clear_req;
        end
        @(posedge clock);
        #1;
        cyc++;
        check_eq("running", int'(running), int'(m_run));
        check_eq("count", int'(count), int'(m_cnt));
        check_eq("clear", int'(clear), int'(m_clr));
        check_eq("count_double", int'(count & last_count), 0);
        last_count = count;
        if (count) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until the next count pulse, bounded; -1 if none arrives.
    task automatic wait_count(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (count) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b1;
        tick();
        start_stop = 1'b0;
    endtask

    initial begin
        int n;
        int p0;
        bit bad_phase;

        // Button held through reset and released: no toggle.
        reset = 1'b1; start_stop = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
        check_eq("held_no_toggle", int'(running), 0);
        start_stop = 1'b0;
        ticks(3);
        check_eq("release_no_toggle", int'(running), 0);

        // Start and run 240 cycles: 60 pulses on every 4th cycle.
        press_ss();
        check_eq("start_running", int'(running), 1);
        p0 = pulses;
        bad_phase = 1'b0;
        for (int i = 1; i <= 240; i++) begin
            tick();
            if (count && (i % TD) != 0) bad_phase = 1'b1;
            if (i == TD) check_eq("first_pulse", int'(count), 1);
        end
        check_eq("pulses_240", pulses - p0, 60);
        check_eq("pulse_phase", int'(bad_phase), 0);

        // Stop at div_cnt=2, idle 10 cycles, resume: pulse 2 cycles after running rises.
        ticks(2);
        press_ss();
        check_eq("stopped", int'(running), 0);
        p0 = pulses;
        ticks(10);
        check_eq("no_pulse_stopped", pulses - p0, 0);
        press_ss();
        wait_count(10, n);
        check_eq("resume_latency", n, 2);

        // Clear at div_cnt=3 while running.
        ticks(3);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check_eq("clr_pulse", int'(clear), 1);
        check_eq("clr_no_count", int'(count), 0);
        check_eq("clr_running", int'(running), 1);
        wait_count(10, n);
        check_eq("after_clear_latency", n, 4);

        // Simultaneous stop and clear.
        ticks(1);
        start_stop = 1'b1; clear_req = 1'b1;
        tick();
        start_stop = 1'b0; clear_req = 1'b0;
        check_eq("both_clear", int'(clear), 1);
        check_eq("both_stopped", int'(running), 0);
        p0 = pulses;
        ticks(12);
        check_eq("both_no_count", pulses - p0, 0);

        // Reset mid-run at div_cnt=3, then a fresh start.
        press_ss();
        ticks(3);
        reset = 1'b1;
        tick();
        check_eq("rst_running", int'(running), 0);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_clear", int'(clear), 0);
        reset = 1'b0;
        ticks(2);
        press_ss();
        wait_count(10, n);
        check_eq("restart_latency", n, 4);

        // Random button traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            start_stop = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            clear_req  = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            reset      = ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10: clock cycles per count pulse; legal range 2..65535.
REQ-002 The block SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port start_stop, input, 1: level button input; each rising edge toggles run/stop.
REQ-005 The block SHALL have port clear_req, input, 1: level button input; each rising edge requests a clear.
REQ-006 The block SHALL have port count, output, 1: registered one-cycle pulse; drives the 60-count display count input.
REQ-007 The block SHALL have port clear, output, 1: registered one-cycle pulse; drives the 60-count display clear input.
REQ-008 The block SHALL have port running, output, 1: high exactly while the state is RUNNING.

Function
REQ-009 The block SHALL detect edges as input high in the current cycle and registered previous value low; prev registers update every cycle.
REQ-010 The FSM SHALL have two states, STOPPED and RUNNING; transitions occur at the clock edge where a start_stop edge is detected.
REQ-011 running SHALL be decoded from the state register, with no added latency: it goes high in the cycle after the start_stop edge cycle.
REQ-012 The prescaler div_cnt SHALL be $clog2(TICK_DIV) bits wide, increment only in RUNNING, and wrap from TICK_DIV-1 to 0.
REQ-013 When RUNNING and div_cnt==TICK_DIV-1, count SHALL be 1 in the following cycle, otherwise 0; count is never high for two consecutive cycles.
REQ-014 The first count pulse after entering RUNNING from div_cnt=0 SHALL occur TICK_DIV cycles after running rises.
REQ-015 In STOPPED, div_cnt SHALL hold its value, so a resume continues the partial period rather than restarting it.
REQ-016 A stop edge in the cycle where div_cnt==TICK_DIV-1 SHALL suppress that count pulse; div_cnt holds at TICK_DIV-1 and the pulse is emitted one cycle after resume.
REQ-017 A clear_req edge SHALL produce clear=1 for exactly the next cycle, force div_cnt to 0, and suppress any count pulse due in that cycle.
REQ-018 A clear SHALL NOT change the FSM state: clearing while RUNNING keeps counting from a fresh period.
REQ-019 Simultaneous start_stop and clear_req edges SHALL apply both: clear pulse issued, div_cnt=0, state toggled, no count pulse.
REQ-020 A button held high for multiple cycles SHALL count as one edge only.

Reset
REQ-021 When reset is high at a clock edge, the block SHALL set state=STOPPED, div_cnt=0, count=0, clear=0, and running=0 in the next cycle.
REQ-022 Reset SHALL load both prev registers with 1, so a button held through reset does not produce an edge on release of reset.
REQ-023 Reset SHALL take priority over all edges in the same cycle, including mid-RUNNING; no count or clear pulse follows it.

Verification (TICK_DIV=4)
REQ-024 Bench SHALL cover: reset 2 cycles with start_stop=1 held, then released to 0 -> running=0, count=0, clear=0 throughout; no toggle.
REQ-025 Bench SHALL cover: 1-cycle start_stop pulse -> running=1 next cycle; count pulses at cycles 4, 8, 12, ... after running rises; 60 pulses in 240 cycles, each 1 cycle wide.
REQ-026 Bench SHALL cover: stop edge at div_cnt=2 -> no pulses while stopped for 10 cycles; resume -> first pulse 2 cycles after running rises.
REQ-027 Bench SHALL cover: clear_req edge while RUNNING at div_cnt=3 -> clear=1 for 1 cycle, no count that cycle, running stays 1, next count 4 cycles later.
REQ-028 Bench SHALL cover: start_stop and clear_req edges in the same cycle while RUNNING -> clear=1 once, running=0, count=0 thereafter.
REQ-029 Bench SHALL cover: reset asserted mid-RUNNING at div_cnt=3 -> next cycle all outputs 0; after reset release and a fresh start, the first count comes 4 cycles after running rises.
